r22sdf_bitrev_reorder: RTL and testbench



---
 rtl/r22sdf_bitrev_reorder_pkg.sv | 24 ++
 rtl/r22sdf_sdpram.sv | 30 +++
 rtl/r22sdf_bitrev_reorder.sv | 175 +++++++++++++++++
 tb/tb_r22sdf_bitrev_reorder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r22sdf_bitrev_reorder_pkg.sv
// Shared constants and helpers for the R2^2SDF bit-reversed to natural-order reorder buffer.
package r22sdf_bitrev_reorder_pkg;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StFill   = 2'd1;
   localparam logic [1:0] StStream = 2'd2;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((64'd1 << res) < 64'(value)) begin
         res++;
      end
      return res;
   endfunction

   // Reverses the low `width` bits of value; upper result bits are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
      logic [31:0] res;
      res = {<<{value}};
      return res >> (32 - width);
   endfunction

endpackage

// File: rtl/r22sdf_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port, both gated by the enable.
module r22sdf_sdpram #(
   parameter int unsigned DataW = 32,
   parameter int unsigned Depth = 16,
   parameter int unsigned AddrW = 4
) (
   input  logic             clk_i,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [DataW-1:0] rdata_o
);

   logic [DataW-1:0] mem_q [Depth];
   logic [DataW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
         end
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/r22sdf_bitrev_reorder.sv
// Ping-pong reorder buffer converting bit-reversed FFT output frames to natural order,
// with sop/eop framing strobes and a mid-frame sop error pulse.
module r22sdf_bitrev_reorder
   import r22sdf_bitrev_reorder_pkg::*;
#(
   parameter int unsigned data_resolution = 16,
   parameter int unsigned fft_length      = 65536,
   parameter bit          out_ff_en       = 1'b1
) (
   input  logic                       sys_clk,
   input  logic                       sys_nrst,
   input  logic                       sys_en,
   input  logic                       din_sop,
   input  logic [data_resolution-1:0] din_r,
   input  logic [data_resolution-1:0] din_i,
   output logic [data_resolution-1:0] dout_r,
   output logic [data_resolution-1:0] dout_i,
   output logic                       dout_valid,
   output logic                       dout_sop,
   output logic                       dout_eop,
   output logic                       sync_err
);

   localparam int unsigned      AddrW   = clog2(fft_length);
   localparam int unsigned      DataW   = 2 * data_resolution;
   localparam int unsigned      PipeW   = DataW + 3;  // {valid, sop, eop, re, im}
   localparam logic [AddrW-1:0] LastIdx = AddrW'(fft_length - 1);
   localparam logic [AddrW-1:0] One     = AddrW'(1);

   logic [1:0]       state_q, state_d;
   logic [AddrW-1:0] wr_cnt_q, wr_cnt_d;
   logic [AddrW-1:0] rd_cnt_q, rd_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_act_q, rd_act_d;
   logic             sync_err_q, sync_err_d;

   logic             restart, wrap, wr_en, rd_fire;
   logic [AddrW-1:0] waddr;
   logic [DataW-1:0] wdata, rdata0, rdata1;

   logic             s1_valid_q, s1_sop_q, s1_eop_q, s1_sel_q;
   logic [PipeW-1:0] s2_q, s2_d, out_w;

   always_comb begin
      restart = (state_q != StIdle) && din_sop && (wr_cnt_q != '0);
      wr_en   = (state_q != StIdle) || din_sop;
      wrap    = (state_q != StIdle) && !restart && (wr_cnt_q == LastIdx);
      rd_fire = (state_q == StStream) && rd_act_q;
      waddr   = restart ? '0 : AddrW'(bitrev(32'(wr_cnt_q), AddrW));
      wdata   = {din_r, din_i};
   end

   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      wr_bank_d  = wr_bank_q;
      rd_act_d   = rd_act_q;
      sync_err_d = restart;
      // A restarted write frame lags the reads; the read bank drains and then waits for the wrap.
      if (rd_fire) begin
         rd_cnt_d = rd_cnt_q + One;
         if (rd_cnt_q == LastIdx) begin
            rd_act_d = 1'b0;
         end
      end
      case (state_q)
         StIdle: begin
            if (din_sop) begin
               wr_cnt_d = One;
               state_d  = StFill;
            end
         end
         StFill, StStream: begin
            wr_cnt_d = restart ? One : wr_cnt_q + One;
            if (wrap) begin
               wr_bank_d = ~wr_bank_q;
               rd_cnt_d  = '0;
               rd_act_d  = 1'b1;
               state_d   = StStream;
            end
         end
         default: begin
            state_d  = StIdle;
            wr_cnt_d = '0;
            rd_act_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         state_q    <= StIdle;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         wr_bank_q  <= 1'b0;
         rd_act_q   <= 1'b0;
         sync_err_q <= 1'b0;
      end else if (sys_en) begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_bank_q  <= wr_bank_d;
         rd_act_q   <= rd_act_d;
         sync_err_q <= sync_err_d;
      end
   end

   r22sdf_sdpram #(
      .DataW (DataW),
      .Depth (fft_length),
      .AddrW (AddrW)
   ) u_ping (
      .clk_i   (sys_clk),
      .en_i    (sys_en),
      .we_i    (wr_en && !wr_bank_q),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (rd_cnt_q),
      .rdata_o (rdata0)
   );

   r22sdf_sdpram #(
      .DataW (DataW),
      .Depth (fft_length),
      .AddrW (AddrW)
   ) u_pong (
      .clk_i   (sys_clk),
      .en_i    (sys_en),
      .we_i    (wr_en && wr_bank_q),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (rd_cnt_q),
      .rdata_o (rdata1)
   );

   // Bank select is captured with the address since wr_bank may toggle on the same edge.
   always_comb begin
      s2_d = s1_valid_q ? {1'b1, s1_sop_q, s1_eop_q, (s1_sel_q ? rdata1 : rdata0)} : '0;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_nrst) begin
         s1_valid_q <= 1'b0;
         s1_sop_q   <= 1'b0;
         s1_eop_q   <= 1'b0;
         s1_sel_q   <= 1'b0;
         s2_q       <= '0;
      end else if (sys_en) begin
         s1_valid_q <= rd_fire;
         s1_sop_q   <= rd_fire && (rd_cnt_q == '0);
         s1_eop_q   <= rd_fire && (rd_cnt_q == LastIdx);
         s1_sel_q   <= ~wr_bank_q;
         s2_q       <= s2_d;
      end
   end

   if (out_ff_en) begin : g_out_ff
      logic [PipeW-1:0] s3_q;
      always_ff @(posedge sys_clk) begin
         if (!sys_nrst) begin
            s3_q <= '0;
         end else if (sys_en) begin
            s3_q <= s2_q;
         end
      end
      assign out_w = s3_q;
   end else begin : g_no_out_ff
      assign out_w = s2_q;
   end

   assign {dout_valid, dout_sop, dout_eop, dout_r, dout_i} = out_w;
   assign sync_err = sync_err_q;

endmodule

// File: tb/tb_r22sdf_bitrev_reorder.sv
// Bench for the reorder buffer: a frame-level model predicts every output cycle of two instances
// (N=16 without output flop, N=64 with it) fed by one shared randomized stimulus stream.
module tb_r22sdf_bitrev_reorder;

   localparam int unsigned DW = 16;

   typedef struct packed {
      logic          valid;
      logic          sop;
      logic          eop;
      logic          serr;
      logic [DW-1:0] r;
      logic [DW-1:0] i;
   } obs_t;

   logic          sys_clk = 1'b0;
   logic          sys_nrst, sys_en, din_sop;
   logic [DW-1:0] din_r, din_i;
   logic [DW-1:0] d0_r, d0_i, d1_r, d1_i;
   logic          d0_valid, d0_sop, d0_eop, d0_serr;
   logic          d1_valid, d1_sop, d1_eop, d1_serr;

   always #5 sys_clk = ~sys_clk;

   r22sdf_bitrev_reorder #(
      .data_resolution (DW),
      .fft_length      (16),
      .out_ff_en       (1'b0)
   ) u_dut0 (
      .sys_clk    (sys_clk),
      .sys_nrst   (sys_nrst),
      .sys_en     (sys_en),
      .din_sop    (din_sop),
      .din_r      (din_r),
      .din_i      (din_i),
      .dout_r     (d0_r),
      .dout_i     (d0_i),
      .dout_valid (d0_valid),
      .dout_sop   (d0_sop),
      .dout_eop   (d0_eop),
      .sync_err   (d0_serr)
   );

   r22sdf_bitrev_reorder #(
      .data_resolution (DW),
      .fft_length      (64),
      .out_ff_en       (1'b1)
   ) u_dut1 (
      .sys_clk    (sys_clk),
      .sys_nrst   (sys_nrst),
      .sys_en     (sys_en),
      .din_sop    (din_sop),
      .din_r      (din_r),
      .din_i      (din_i),
      .dout_r     (d1_r),
      .dout_i     (d1_i),
      .dout_valid (d1_valid),
      .dout_sop   (d1_sop),
      .dout_eop   (d1_eop),
      .sync_err   (d1_serr)
   );

   int total = 0;
   int bad   = 0;
   int ecnt  = 0;
   int serr_cnt0 = 0;
   int cap_sel = -1;
   obs_t cap_q [$];
   int   cap_e [$];

   bit            m_act   [2];
   int            m_k     [2];
   logic [2*DW-1:0] m_frame [2][64];
   obs_t          m_last  [2];
   obs_t          exp_map [int];

   function automatic int nn(input int j);
      return (j == 0) ? 16 : 64;
   endfunction

   function automatic int aw(input int j);
      return (j == 0) ? 4 : 6;
   endfunction

   function automatic int lat(input int j);
      return (j == 0) ? 2 : 3;
   endfunction

   function automatic int bitrev_tb(input int v, input int w);
      int res;
      res = 0;
      for (int b = 0; b < w; b++) begin
         if (((v >> b) & 1) != 0) res += 1 << (w - 1 - b);
      end
      return res;
   endfunction

   function automatic obs_t got_obs(input int j);
      obs_t o;
      if (j == 0) o = {d0_valid, d0_sop, d0_eop, d0_serr, d0_r, d0_i};
      else        o = {d1_valid, d1_sop, d1_eop, d1_serr, d1_r, d1_i};
      return o;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end
   endtask

   // One clock: drive inputs, advance the frame model, compare both DUTs against it.
   task automatic step(input bit nrst, input bit en, input bit sop,
                       input logic [DW-1:0] r, input logic [DW-1:0] i);
      obs_t e, s, g;
      int   key;
      sys_nrst = nrst;
      sys_en   = en;
      din_sop  = sop;
      din_r    = r;
      din_i    = i;
      @(posedge sys_clk);
      #1;
      if (!nrst) begin
         exp_map.delete();
         for (int j = 0; j < 2; j++) begin
            m_act[j]  = 1'b0;
            m_k[j]    = 0;
            m_last[j] = '0;
         end
      end else if (en) begin
         ecnt++;
         for (int j = 0; j < 2; j++) begin
            e = '0;
            if (m_act[j] || sop) begin
               m_act[j] = 1'b1;
               if (sop && m_k[j] != 0) e.serr = 1'b1;
               if (sop) m_k[j] = 0;
               m_frame[j][m_k[j]] = {r, i};
               m_k[j]++;
               if (m_k[j] == nn(j)) begin
                  for (int n = 0; n < nn(j); n++) begin
                     s       = '0;
                     s.valid = 1'b1;
                     s.sop   = (n == 0);
                     s.eop   = (n == nn(j) - 1);
                     {s.r, s.i} = m_frame[j][bitrev_tb(n, aw(j))];
                     exp_map[(ecnt + lat(j) + n) * 2 + j] = s;
                  end
                  m_k[j] = 0;
               end
            end
            key = ecnt * 2 + j;
            if (exp_map.exists(key)) begin
               s       = exp_map[key];
               e.valid = s.valid;
               e.sop   = s.sop;
               e.eop   = s.eop;
               e.r     = s.r;
               e.i     = s.i;
               exp_map.delete(key);
            end
            m_last[j] = e;
         end
      end
      for (int j = 0; j < 2; j++) begin
         g = got_obs(j);
         total++;
         if (g !== m_last[j]) begin
            bad++;
            $display("FAIL out_dut%0d ecyc %0d: got v=%b s=%b e=%b err=%b r=%h i=%h required v=%b s=%b e=%b err=%b r=%h i=%h",
                     j, ecnt, g.valid, g.sop, g.eop, g.serr, g.r, g.i,
                     m_last[j].valid, m_last[j].sop, m_last[j].eop, m_last[j].serr,
                     m_last[j].r, m_last[j].i);
         end
      end
      if (nrst && en) begin
         if (d0_serr) serr_cnt0++;
         if (cap_sel >= 0) begin
            g = got_obs(cap_sel);
            if (g.valid) begin
               cap_q.push_back(g);
               cap_e.push_back(ecnt);
            end
         end
      end
   endtask

   // mode 0 random data, 1 bit-reversed index pattern, 2 single impulse at sample 0.
   task automatic feed(input int samples, input int period, input int low_pct, input int mode);
      int            p;
      bit            en;
      logic [DW-1:0] r, i;
      p = 0;
      while (p < samples) begin
         en = ($urandom_range(0, 99) >= low_pct);
         case (mode)
            1: begin
               r = DW'(bitrev_tb(p % 16, 4));
               i = -r;
            end
            2: begin
               r = (p == 0) ? 16'h7FFF : 16'h0000;
               i = '0;
            end
            default: begin
               r = DW'($urandom);
               i = DW'($urandom);
            end
         endcase
         step(1'b1, en, (p % period == 0), r, i);
         if (en) p++;
      end
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1, 1'b0, '0, '0);
   endtask

   initial begin
      int   e0, nz, eops;
      obs_t c;
      sys_nrst = 1'b0;
      sys_en   = 1'b0;
      din_sop  = 1'b0;
      din_r    = '0;
      din_i    = '0;
      for (int k = 0; k < 3; k++) do_reset();
      chk("reset_dut0", 64'(got_obs(0)), 64'd0);
      chk("reset_dut1", 64'(got_obs(1)), 64'd0);

      // Bit-reversed index pattern must come out as 0..15 / 0..-15.
      e0 = ecnt;
      cap_sel = 0;
      feed(48, 16, 0, 1);
      cap_sel = -1;
      chk("order_count", 64'(cap_q.size() >= 16), 64'd1);
      if (cap_e.size() > 0) chk("x0_latency", 64'(cap_e[0] - e0), 64'd18);
      for (int n = 0; n < 16 && n < cap_q.size(); n++) begin
         c = cap_q[n];
         chk("natural_order", {30'd0, c.r, c.i, c.sop, c.eop},
             {30'd0, 16'(n), 16'(-n), (n == 0), (n == 15)});
      end
      cap_q.delete();
      cap_e.delete();

      feed(64, 16, 0, 0);
      feed(96, 16, 30, 0);

      // Unexpected sop at position 7 of frame 2.
      do_reset();
      serr_cnt0 = 0;
      for (int p = 0; p < 23 + 48; p++) begin
         step(1'b1, 1'b1, (p == 0) || (p == 16) || (p >= 23 && (p - 23) % 16 == 0),
              DW'($urandom), DW'($urandom));
      end
      chk("sync_err_pulses", 64'(serr_cnt0), 64'd1);
      feed(32, 16, 0, 0);

      // Reset while the read side is at rd_cnt=9.
      do_reset();
      for (int p = 0; p < 25; p++) begin
         step(1'b1, 1'b1, (p % 16 == 0), DW'($urandom), DW'($urandom));
      end
      do_reset();
      chk("midreset_dut0", 64'(got_obs(0)), 64'd0);
      chk("midreset_dut1", 64'(got_obs(1)), 64'd0);
      for (int p = 0; p < 20; p++) step(1'b1, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
      chk("nosop_ignored", 64'(got_obs(0)), 64'd0);
      feed(48, 16, 0, 0);

      // Impulse frame on the N=64 instance.
      do_reset();
      cap_sel = 1;
      feed(192, 64, 0, 2);
      cap_sel = -1;
      chk("impulse_count", 64'(cap_q.size() >= 64), 64'd1);
      if (cap_q.size() >= 64) begin
         chk("impulse_x0", {31'd0, cap_q[0].r, cap_q[0].i, cap_q[0].sop}, {31'd0, 16'h7FFF, 16'h0000, 1'b1});
         nz = 0;
         eops = 0;
         for (int n = 1; n < 64; n++) begin
            if (cap_q[n].r != 0 || cap_q[n].i != 0) nz++;
            if (cap_q[n].eop) eops++;
         end
         chk("impulse_zeros", 64'(nz), 64'd0);
         chk("impulse_eop63", 64'(cap_q[63].eop), 64'd1);
         chk("impulse_eop_once", 64'(eops), 64'd1);
      end

      feed(192, 64, 30, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
